// File: rtl/alu4_operand_loader.sv
// alu4_operand_loader: collects opcode/A/B nibbles from a valid/ready
// stream and issues them as one registered ALU command.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           abort a partially collected command
//   in_valid/in_data/in_ready   nibble input stream
//   op_valid/op_ready           command output handshake
//   op_code, op_cin, op_a, op_b command fields
//   issue_count     completed output handshakes (wraps)
module alu4_operand_loader #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [3:0]       in_data,
   output logic             in_ready,
   output logic             op_valid,
   input  logic             op_ready,
   output logic [2:0]       op_code,
   output logic             op_cin,
   output logic [3:0]       op_a,
   output logic [3:0]       op_b,
   output logic [CNT_W-1:0] issue_count
);

   typedef enum logic [1:0] {
      S_OPC = 2'd0,
      S_A   = 2'd1,
      S_B   = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nx;
   logic [2:0] stg_code;
   logic       stg_cin;
   logic [3:0] stg_a;
   logic       in_fire;
   logic       b_fire;
   logic       op_fire;

   always_comb begin
      in_ready = 1'b0;
      state_nx = state;
      unique case (state)
         S_OPC:   in_ready = 1'b1;
         S_A:     in_ready = 1'b1;
         // Only take B when the holding register is empty or draining.
         S_B:     in_ready = !op_valid || op_ready;
         default: in_ready = 1'b0;
      endcase
      if (rst || flush)
         in_ready = 1'b0;

      in_fire = in_valid && in_ready;
      b_fire  = in_fire && (state == S_B);
      op_fire = op_valid && op_ready;

      if (flush) begin
         state_nx = S_OPC;
      end else if (in_fire) begin
         unique case (state)
            S_OPC:   state_nx = S_A;
            S_A:     state_nx = S_B;
            S_B:     state_nx = S_OPC;
            default: state_nx = S_OPC;
         endcase
      end else if (state == 2'd3) begin
         state_nx = S_OPC;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_OPC;
         stg_code    <= '0;
         stg_cin     <= 1'b0;
         stg_a       <= '0;
         op_valid    <= 1'b0;
         op_code     <= '0;
         op_cin      <= 1'b0;
         op_a        <= '0;
         op_b        <= '0;
         issue_count <= '0;
      end else begin
         state <= state_nx;

         if (flush) begin
            stg_code <= '0;
            stg_cin  <= 1'b0;
            stg_a    <= '0;
         end else if (in_fire && state == S_OPC) begin
            stg_code <= in_data[2:0];
            stg_cin  <= in_data[3];
         end else if (in_fire && state == S_A) begin
            stg_a <= in_data;
         end

         // A new command may replace the leaving one in the same cycle.
         if (b_fire) begin
            op_valid <= 1'b1;
            op_code  <= stg_code;
            op_cin   <= stg_cin;
            op_a     <= stg_a;
            op_b     <= in_data;
         end else if (op_fire) begin
            op_valid <= 1'b0;
         end

         if (op_fire)
            issue_count <= issue_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_alu4_operand_loader.sv
// tb_alu4_operand_loader: table vectors, directed wrap test and random
// traffic checked against a queue-based reference model.
module tb_alu4_operand_loader;

   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst, flush, in_valid, in_ready;
   logic [3:0]       in_data;
   logic             op_valid, op_ready, op_cin;
   logic [2:0]       op_code;
   logic [3:0]       op_a, op_b;
   logic [CNT_W-1:0] issue_count;

   alu4_operand_loader #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .op_valid(op_valid), .op_ready(op_ready),
      .op_code(op_code), .op_cin(op_cin), .op_a(op_a), .op_b(op_b),
      .issue_count(issue_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: nibbles gathered in a queue, one held command.
   logic [3:0] m_q[$];
   bit         m_val;
   logic [2:0] m_code;
   logic       m_cin;
   logic [3:0] m_a, m_b;
   int         m_cnt;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t: got %0h expected %0h",
                  name, $time, act, exp);
      end
   endtask

   task automatic m_reset();
      m_q.delete();
      m_val = 0; m_code = 0; m_cin = 0; m_a = 0; m_b = 0; m_cnt = 0;
   endtask

   function automatic bit m_in_ready();
      if (rst || flush) return 0;
      if (m_q.size() < 2) return 1;
      return !m_val || op_ready;
   endfunction

   task automatic check_model();
      chk("m_in_ready", 32'(in_ready), 32'(m_in_ready()));
      chk("m_op_valid", 32'(op_valid), 32'(m_val));
      chk("m_op_code", 32'(op_code), 32'(m_code));
      chk("m_op_cin", 32'(op_cin), 32'(m_cin));
      chk("m_op_a", 32'(op_a), 32'(m_a));
      chk("m_op_b", 32'(op_b), 32'(m_b));
      chk("m_count", 32'(issue_count), 32'(m_cnt));
   endtask

   task automatic model_step();
      bit rdy_in;
      if (rst) begin
         m_reset();
         return;
      end
      rdy_in = m_in_ready();
      if (m_val && op_ready) begin
         m_cnt = (m_cnt + 1) % (1 << CNT_W);
         m_val = 0;
      end
      if (flush) begin
         m_q.delete();
      end else if (in_valid && rdy_in) begin
         m_q.push_back(in_data);
         if (m_q.size() == 3) begin
            m_code = m_q[0][2:0];
            m_cin  = m_q[0][3];
            m_a    = m_q[1];
            m_b    = m_q[2];
            m_val  = 1;
            m_q.delete();
         end
      end
   endtask

   task automatic drive(input logic r, input logic f, input logic v,
                        input logic [3:0] d, input logic rd);
      rst = r; flush = f; in_valid = v; in_data = d; op_ready = rd;
      @(negedge clk);
      check_model();
   endtask

   task automatic advance();
      model_step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic r, f, v;
      logic [3:0] d;
      logic rd;
      logic e_ir, e_val;
      logic [2:0] e_code;
      logic e_cin;
      logic [3:0] e_a, e_b;
      int e_cnt;
   } vec_t;

   vec_t tbl[31];

   initial begin
      tbl = '{
         //  r f v  d    rd  ir val code cin a    b    cnt
         '{1,0,0,4'h0,0, 0,0, 0,0,4'h0,4'h0, 0},
         '{0,0,1,4'hB,1, 1,0, 0,0,4'h0,4'h0, 0},
         '{0,0,1,4'h7,1, 1,0, 0,0,4'h0,4'h0, 0},
         '{0,0,1,4'h5,1, 1,0, 0,0,4'h0,4'h0, 0},
         '{0,0,0,4'h0,1, 1,1, 3,1,4'h7,4'h5, 0},
         '{0,0,0,4'h0,1, 1,0, 3,1,4'h7,4'h5, 1},
         '{0,0,1,4'h2,0, 1,0, 3,1,4'h7,4'h5, 1},
         '{0,0,1,4'h1,0, 1,0, 3,1,4'h7,4'h5, 1},
         '{0,0,1,4'h3,0, 1,0, 3,1,4'h7,4'h5, 1},
         '{0,0,1,4'hC,0, 1,1, 2,0,4'h1,4'h3, 1},
         '{0,0,1,4'h6,0, 1,1, 2,0,4'h1,4'h3, 1},
         '{0,0,1,4'h9,0, 0,1, 2,0,4'h1,4'h3, 1},
         '{0,0,1,4'h9,1, 1,1, 2,0,4'h1,4'h3, 1},
         '{0,0,0,4'h0,0, 1,1, 4,1,4'h6,4'h9, 2},
         '{0,0,0,4'h0,1, 1,1, 4,1,4'h6,4'h9, 2},
         '{0,0,1,4'h2,0, 1,0, 4,1,4'h6,4'h9, 3},
         '{0,0,1,4'h9,0, 1,0, 4,1,4'h6,4'h9, 3},
         '{0,1,1,4'h5,0, 0,0, 4,1,4'h6,4'h9, 3},
         '{0,0,1,4'h1,0, 1,0, 4,1,4'h6,4'h9, 3},
         '{0,0,1,4'h3,0, 1,0, 4,1,4'h6,4'h9, 3},
         '{0,0,1,4'h4,0, 1,0, 4,1,4'h6,4'h9, 3},
         '{0,0,0,4'h0,0, 1,1, 1,0,4'h3,4'h4, 3},
         '{0,1,0,4'h0,1, 0,1, 1,0,4'h3,4'h4, 3},
         '{0,0,0,4'h0,0, 1,0, 1,0,4'h3,4'h4, 4},
         '{0,0,1,4'hA,0, 1,0, 1,0,4'h3,4'h4, 4},
         '{0,0,1,4'h8,0, 1,0, 1,0,4'h3,4'h4, 4},
         '{0,0,1,4'hF,0, 1,0, 1,0,4'h3,4'h4, 4},
         '{0,0,1,4'h7,0, 1,1, 2,1,4'h8,4'hF, 4},
         '{0,0,1,4'h6,0, 1,1, 2,1,4'h8,4'hF, 4},
         '{1,0,1,4'h5,1, 0,1, 2,1,4'h8,4'hF, 4},
         '{0,0,0,4'h0,1, 1,0, 0,0,4'h0,4'h0, 0}
      };

      rst = 1; flush = 0; in_valid = 0; in_data = 0; op_ready = 0;
      m_reset();
      @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         drive(tbl[i].r, tbl[i].f, tbl[i].v, tbl[i].d, tbl[i].rd);
         chk($sformatf("t%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
         chk($sformatf("t%0d_op_valid", i), 32'(op_valid), 32'(tbl[i].e_val));
         chk($sformatf("t%0d_op_code", i), 32'(op_code), 32'(tbl[i].e_code));
         chk($sformatf("t%0d_op_cin", i), 32'(op_cin), 32'(tbl[i].e_cin));
         chk($sformatf("t%0d_op_a", i), 32'(op_a), 32'(tbl[i].e_a));
         chk($sformatf("t%0d_op_b", i), 32'(op_b), 32'(tbl[i].e_b));
         chk($sformatf("t%0d_count", i), 32'(issue_count), 32'(tbl[i].e_cnt));
         advance();
      end

      // Counter wrap: 256 commands from a fresh reset, op_ready high.
      drive(1, 0, 0, 4'h0, 1);
      advance();
      for (int c = 0; c < 256; c++) begin
         for (int n = 0; n < 3; n++) begin
            drive(0, 0, 1, 4'($urandom_range(0, 15)), 1);
            advance();
         end
      end
      drive(0, 0, 0, 4'h0, 1);
      chk("wrap_255", 32'(issue_count), 32'd255);
      chk("wrap_valid", 32'(op_valid), 32'd1);
      advance();
      drive(0, 0, 0, 4'h0, 1);
      chk("wrap_0", 32'(issue_count), 32'd0);
      advance();

      // Random traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         drive(($urandom_range(0, 63) == 0),
               ($urandom_range(0, 15) == 0),
               1'($urandom),
               4'($urandom),
               ($urandom_range(0, 3) != 0));
         advance();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
